// File: rtl/reg_file_sync.sv
// reg_file_sync: parametrised register file, two registered read ports, one write port.
// Latency: reads return one clk after the address is sampled; writes land at the clk edge.
// Backpressure: none; writes arriving while busy (or alongside clear_req) are dropped and flagged on wr_drop.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   clear_req             pulse that restarts the zeroing sequence
//   wr_en/wr_addr/wr_data write port
//   rd_addr_a/rd_data_a   read port A (registered data)
//   rd_addr_b/rd_data_b   read port B (registered data)
//   busy                  high while the zeroing sequence is running
//   wr_drop               one-cycle pulse for each rejected write
//
// Build option: define REGFILE_BYPASS_EN for write-first behaviour on a same-cycle
// read/write to the same address; otherwise reads return the old contents.
module reg_file_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_zero;   // write targets the hardwired zero entry
  logic wr_ok;     // write is accepted and actually updates the array
  logic clr_wr;    // clear sequencer zeroes entry clr_cnt this cycle
  logic zero_a;
  logic zero_b;
  logic hit_a;
  logic hit_b;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok   = !reset && (state == READY) && wr_en && !clear_req && !wr_zero;
  // A clear_req restarts the sequence, so that cycle's zeroing step is skipped.
  assign clr_wr  = !reset && (state == CLEAR) && !clear_req;
  assign zero_a  = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b  = (ZERO_REG != 0) && (rd_addr_b == '0);

`ifdef REGFILE_BYPASS_EN
  assign hit_a = wr_ok && (wr_addr == rd_addr_a);
  assign hit_b = wr_ok && (wr_addr == rd_addr_b);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  // Storage has no reset: contents become defined once a clear pass completes.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      busy      <= 1'b1;
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_drop   <= 1'b0;
    end else begin
      // Writes are rejected while clearing and when a clear is requested.
      wr_drop <= wr_en && ((state == CLEAR) || clear_req);

      // Zero-register and clearing rules take precedence over bypass.
      if ((state == CLEAR) || zero_a) begin
        rd_data_a <= '0;
      end else if (hit_a) begin
        rd_data_a <= wr_data;
      end else begin
        rd_data_a <= mem[rd_addr_a];
      end

      if ((state == CLEAR) || zero_b) begin
        rd_data_b <= '0;
      end else if (hit_b) begin
        rd_data_b <= wr_data;
      end else begin
        rd_data_b <= mem[rd_addr_b];
      end

      if (clear_req) begin
        state   <= CLEAR;
        clr_cnt <= '0;
        busy    <= 1'b1;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state <= READY;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sync.sv
module tb_reg_file_sync;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          busy;
  logic          wr_drop;

  always #5 clk = ~clk;

  reg_file_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .busy(busy), .wr_drop(wr_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a plain array plus "clearing in progress, next index".
  logic [DW-1:0] m [DEPTH];
  bit            m_clearing = 1'b1;
  int            m_pos = 0;
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_busy, exp_drop;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit wacc);
    if (ZR != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wacc && wr_addr == a) return wr_data;
`endif
    return m[a];
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    bit wacc;
    if (reset) begin
      exp_a = '0; exp_b = '0; exp_drop = 1'b0;
      m_clearing = 1'b1; m_pos = 0;
    end else begin
      wacc = !m_clearing && !clear_req && wr_en && !(ZR != 0 && wr_addr == 0);
      exp_a    = m_clearing ? '0 : model_read(rd_addr_a, wacc);
      exp_b    = m_clearing ? '0 : model_read(rd_addr_b, wacc);
      exp_drop = wr_en && (m_clearing || clear_req);
      if (wacc) m[wr_addr] = wr_data;
      if (clear_req) begin
        m_clearing = 1'b1; m_pos = 0;
      end else if (m_clearing) begin
        m[m_pos] = '0;
        m_pos++;
        if (m_pos == DEPTH) m_clearing = 1'b0;
      end
    end
    exp_busy = m_clearing;
  endtask

  // One clock: update model, let the edge happen, compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("rd_data_a", rd_data_a, exp_a);
    check("rd_data_b", rd_data_b, exp_b);
    check("busy", {31'b0, busy}, {31'b0, exp_busy});
    check("wr_drop", {31'b0, wr_drop}, {31'b0, exp_drop});
  endtask

  task automatic idle();
    reset = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // Runs cycles until busy drops; returns how many it took (capped).
  task automatic count_busy(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy !== 1'b0 && n < 100);
  endtask

  int n;

  initial begin
    for (int i = 0; i < DEPTH; i++) m[i] = '0;

    // Reset
    reset = 1'b1;
    cycle();
    cycle();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd_a", rd_data_a, 32'h0);

    // Release: busy for DEPTH cycles; a write to 9 during the window is dropped.
    idle();
    cycle(); cycle(); cycle();
    write(5'd9, 32'hFF);
    cycle();
    idle();
    check("drop_in_busy", {31'b0, wr_drop}, 32'd1);
    n = 4;
    while (busy !== 1'b0 && n < 100) begin
      cycle();
      n++;
    end
    check("busy_len_reset", n, 32'd32);

    // Every address on both ports reads 0.
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH - 1 - i);
      cycle();
    end
    rd_addr_a = 5'd9;
    cycle();
    check("addr9_after_clear", rd_data_a, 32'h0);

    // Write / read back through both ports.
    write(5'd7, 32'hDEADBEEF);
    cycle();
    idle();
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    cycle();
    check("rd7_a", rd_data_a, 32'hDEADBEEF);
    check("rd7_b", rd_data_b, 32'hDEADBEEF);

    // Zero register ignores writes, silently.
    write(5'd0, 32'h12345678);
    cycle();
    check("zero_no_drop", {31'b0, wr_drop}, 32'd0);
    idle();
    rd_addr_a = 5'd0;
    cycle();
    check("zero_read", rd_data_a, 32'h0);

    // Same-cycle read/write collision on address 3.
    write(5'd3, 32'h11);
    cycle();
    write(5'd3, 32'hA5A5A5A5);
    rd_addr_b = 5'd3;
    cycle();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("collide_b", rd_data_b, 32'hA5A5A5A5);
`else
    check("collide_b", rd_data_b, 32'h11);
`endif
    cycle();
    check("collide_b_next", rd_data_b, 32'hA5A5A5A5);

    // clear_req after writing 31 (a write with it is dropped).
    write(5'd31, 32'h55);
    cycle();
    clear_req = 1'b1;
    write(5'd4, 32'h77);
    cycle();
    idle();
    check("drop_with_clear", {31'b0, wr_drop}, 32'd1);
    count_busy(n);
    check("busy_len_clear", n, 32'd32);
    rd_addr_a = 5'd31; rd_addr_b = 5'd4;
    cycle();
    check("rd31_cleared", rd_data_a, 32'h0);
    check("rd4_dropped", rd_data_b, 32'h0);

    // Reset 10 cycles into a clear restarts the full sequence.
    write(5'd31, 32'h55);
    cycle();
    idle();
    clear_req = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 10; i++) cycle();
    reset = 1'b1;
    cycle();
    idle();
    count_busy(n);
    check("busy_len_midreset", n, 32'd32);
    rd_addr_a = 5'd31;
    cycle();
    check("rd31_after_reset", rd_data_a, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_req = ($urandom_range(0, 79) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sync.md
Name: reg_file_sync

Overview:
- Parametrised synchronous register file; next generation of the CPU datapath register store.
- Two registered read ports and one write port, with an optional hardwired zero register.
- A hardware clear sequencer zeroes every entry after reset or on request, so no file-based initialisation is needed.
- Sits between decode (read addresses) and writeback (write port) of the single-cycle/multicycle core.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear_req  input  1  one-cycle pulse; restarts the full clear sequence.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr_a  input  ADDR_WIDTH  port A read address.
- rd_data_a  output  DATA_WIDTH  port A data, registered.
- rd_addr_b  input  ADDR_WIDTH  port B read address.
- rd_data_b  output  DATA_WIDTH  port B data, registered.
- busy  output  1  high while the clear sequence runs.
- wr_drop  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- FSM states: CLEAR and READY.
- Reset (sampled at clk edge):
  - state = CLEAR, clr_cnt = 0, busy = 1.
  - rd_data_a = rd_data_b = 0, wr_drop = 0.
  - The array is not touched during the reset cycle itself.
- CLEAR state:
  - Each cycle, writes 0 to entry clr_cnt, then clr_cnt increments.
  - When clr_cnt = DEPTH-1 is written, next state = READY.
  - busy falls on the edge that enters READY. After reset release, busy stays high exactly DEPTH cycles (32 at default).
  - Reads return 0 on both ports.
  - wr_en = 1 is ignored and wr_drop pulses the following cycle.
- READY state:
  - wr_en = 1 writes wr_data to wr_addr at the clk edge.
  - A write to addr 0 with ZERO_REG = 1 is silently discarded; no wr_drop.
- clear_req = 1 in any state:
  - next state = CLEAR, clr_cnt = 0.
  - A write in the same cycle is dropped and wr_drop pulses.
  - clear_req during CLEAR restarts the count from 0.
- Reset mid-clear: restarts from clr_cnt = 0; reset has priority over clear_req.
- Reads:
  - Latency 1: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
  - Addr 0 with ZERO_REG = 1 always returns 0.
  - Both ports may read the same address.
- Simultaneous read and write to the same address in the same cycle: governed by the optional feature below.
- wr_drop: registered and high for exactly one cycle per rejected write.
- No X propagation: every entry is defined after the first clear completes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first. If wr_en is accepted and wr_addr == rd_addr_x (and that address is writable), rd_data_x at the next edge = wr_data.
- Undefined: read-first. rd_data_x returns the old contents; the new value is visible one cycle later.
- Zero-register and CLEAR-state rules override bypass in both builds.

Test Plan:
- Reset release, defaults: busy high 32 cycles then low; afterwards reading every address on both ports returns 0x00000000.
- READY, write 0xDEADBEEF to addr 7, next cycle rd_addr_a = 7 -> rd_data_a = 0xDEADBEEF one cycle later; port B on addr 7 gives the same value.
- ZERO_REG = 1, write 0x12345678 to addr 0 -> port A on addr 0 reads 0; wr_drop stays 0.
- Same-cycle write of 0xA5A5A5A5 to addr 3 with rd_addr_b = 3 (old value 0x11):
  - REGFILE_BYPASS_EN defined -> rd_data_b = 0xA5A5A5A5.
  - Undefined -> 0x11 first, then 0xA5A5A5A5 on the next read.
- Write 0xFF to addr 9 during the busy window -> wr_drop pulses one cycle; addr 9 reads 0 after the clear.
- Assert reset 10 cycles into a clear (or pulse clear_req after writing 0x55 to addr 31) -> busy high a full 32 more cycles, then addr 31 reads 0.
